// File: rtl/pong_ball_engine.sv
// Ball physics and scoring for pong: moves the ball once per frame tick, bounces off walls and paddles, counts points.
// Latency: ball registers update 1 clk after tick; no backpressure, tick/serve are sampled every clk.
module pong_ball_engine #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int BALL_SIZE   = 10,
    parameter int PAD_W       = 10,
    parameter int PAD_H       = 50,
    parameter int PAD_L_X     = 20,
    parameter int PAD_R_X     = 620,
    parameter int SPEED_INIT  = 2,
    parameter int SPEED_MAX   = 8,
    parameter int HITS_PER_UP = 4,
    parameter int WIN_SCORE   = 9,
    parameter int SERVE_DELAY = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        serve,
    input  logic [9:0]  pad1_y,
    input  logic [9:0]  pad2_y,
    output logic [10:0] ball_x,
    output logic [9:0]  ball_y,
    output logic [3:0]  score1,
    output logic [3:0]  score2,
    output logic        point_p1,
    output logic        point_p2,
    output logic        game_over,
    output logic [2:0]  state_o
);
    localparam int XW  = 11;
    localparam int YW  = 10;
    localparam int XW1 = XW + 1;
    localparam int YW1 = YW + 1;
    localparam int HW  = $clog2(HITS_PER_UP + 1);
    localparam int DW  = $clog2(SERVE_DELAY + 1);

    localparam logic [XW-1:0] CX       = XW'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [YW-1:0] CY       = YW'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [XW:0]   L_FACE   = XW1'(PAD_L_X + PAD_W);
    localparam logic [XW:0]   R_FACE   = XW1'(PAD_R_X - BALL_SIZE);
    localparam logic [XW:0]   X_MAX    = XW1'(SCREEN_W - BALL_SIZE);
    localparam logic [YW:0]   Y_MAX    = YW1'(SCREEN_H - BALL_SIZE);
    localparam logic [YW:0]   B_SZ     = YW1'(BALL_SIZE);
    localparam logic [YW:0]   P_H      = YW1'(PAD_H);
    localparam logic [YW:0]   VY       = YW1'(SPEED_INIT);
    localparam logic [XW-1:0] V_INIT   = XW'(SPEED_INIT);
    localparam logic [XW-1:0] V_MAX    = XW'(SPEED_MAX);
    localparam logic [HW-1:0] HIT_LAST = HW'(HITS_PER_UP - 1);
    localparam logic [DW-1:0] DLY_LAST = DW'(SERVE_DELAY - 1);
    localparam logic [3:0]    WIN      = 4'(WIN_SCORE);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DELAY = 3'd1,
        S_MOVE  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   ball_x_q, ball_x_d;
    logic [YW-1:0]   ball_y_q, ball_y_d;
    logic            dir_x_q, dir_x_d;     // 1 = moving right
    logic            dir_y_q, dir_y_d;     // 1 = moving down
    logic [XW-1:0]   vx_q, vx_d;
    logic [HW-1:0]   hit_q, hit_d;
    logic [DW-1:0]   delay_q, delay_d;
    logic [3:0]      score1_q, score1_d;
    logic [3:0]      score2_q, score2_d;
    logic            scorer_q, scorer_d;   // 1 = player 1 scored
    logic            hit_now;

    // One extra bit on every sum so no intermediate result can wrap.
    logic [XW:0] bx, vxw, nx_r, nx_l;
    logic [YW:0] by, ny_dn, ny_up, p1w, p2w;
    logic        ovl1, ovl2;
    logic [3:0]  sc1_inc, sc2_inc;

    assign bx    = {1'b0, ball_x_q};
    assign vxw   = {1'b0, vx_q};
    assign nx_r  = bx + vxw;
    assign nx_l  = bx - vxw;
    assign by    = {1'b0, ball_y_q};
    assign ny_dn = by + VY;
    assign ny_up = by - VY;
    assign p1w   = {1'b0, pad1_y};
    assign p2w   = {1'b0, pad2_y};
    assign ovl1  = (by + B_SZ > p1w) && (by < p1w + P_H);
    assign ovl2  = (by + B_SZ > p2w) && (by < p2w + P_H);
    assign sc1_inc = (score1_q == 4'hF) ? 4'hF : score1_q + 4'd1;
    assign sc2_inc = (score2_q == 4'hF) ? 4'hF : score2_q + 4'd1;

    always_comb begin
        state_d  = state_q;
        ball_x_d = ball_x_q;
        ball_y_d = ball_y_q;
        dir_x_d  = dir_x_q;
        dir_y_d  = dir_y_q;
        vx_d     = vx_q;
        hit_d    = hit_q;
        delay_d  = delay_q;
        score1_d = score1_q;
        score2_d = score2_q;
        scorer_d = scorer_q;
        hit_now  = 1'b0;

        case (state_q)
            S_IDLE: begin
                ball_x_d = CX;
                ball_y_d = CY;
                if (serve) begin
                    state_d = S_DELAY;
                    delay_d = '0;
                end
            end
            S_DELAY: begin
                ball_x_d = CX;
                ball_y_d = CY;
                if (tick) begin
                    if (delay_q == DLY_LAST) begin
                        state_d = S_MOVE;
                        delay_d = '0;
                    end else begin
                        delay_d = delay_q + 1'b1;
                    end
                end
            end
            S_MOVE: begin
                if (tick) begin
                    if (dir_y_q) begin
                        if (ny_dn >= Y_MAX) begin
                            ball_y_d = Y_MAX[YW-1:0];
                            dir_y_d  = 1'b0;
                        end else begin
                            ball_y_d = ny_dn[YW-1:0];
                        end
                    end else begin
                        if (by <= VY) begin
                            ball_y_d = '0;
                            dir_y_d  = 1'b1;
                        end else begin
                            ball_y_d = ny_up[YW-1:0];
                        end
                    end

                    // Paddle face is tested before the goal line so a fast ball cannot tunnel through.
                    if (!dir_x_q) begin
                        if (bx >= L_FACE && bx <= L_FACE + vxw && ovl1) begin
                            ball_x_d = L_FACE[XW-1:0];
                            dir_x_d  = 1'b1;
                            hit_now  = 1'b1;
                        end else if (bx <= vxw) begin
                            ball_x_d = '0;
                            scorer_d = 1'b0;
                            state_d  = S_POINT;
                        end else begin
                            ball_x_d = nx_l[XW-1:0];
                        end
                    end else begin
                        if (bx <= R_FACE && nx_r >= R_FACE && ovl2) begin
                            ball_x_d = R_FACE[XW-1:0];
                            dir_x_d  = 1'b0;
                            hit_now  = 1'b1;
                        end else if (nx_r >= X_MAX) begin
                            ball_x_d = X_MAX[XW-1:0];
                            scorer_d = 1'b1;
                            state_d  = S_POINT;
                        end else begin
                            ball_x_d = nx_r[XW-1:0];
                        end
                    end
                end
            end
            S_POINT: begin
                ball_x_d = CX;
                ball_y_d = CY;
                vx_d     = V_INIT;
                hit_d    = '0;
                delay_d  = '0;
                dir_y_d  = ~dir_y_q;
                if (scorer_q) begin
                    score1_d = sc1_inc;
                    dir_x_d  = 1'b1;
                    state_d  = (sc1_inc == WIN) ? S_OVER : S_DELAY;
                end else begin
                    score2_d = sc2_inc;
                    dir_x_d  = 1'b0;
                    state_d  = (sc2_inc == WIN) ? S_OVER : S_DELAY;
                end
            end
            S_OVER: begin
                ball_x_d = CX;
                ball_y_d = CY;
                if (serve) begin
                    score1_d = '0;
                    score2_d = '0;
                    dir_x_d  = 1'b1;
                    delay_d  = '0;
                    state_d  = S_DELAY;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (hit_now) begin
            if (hit_q == HIT_LAST) begin
                hit_d = '0;
                vx_d  = (vx_q >= V_MAX) ? V_MAX : vx_q + 1'b1;
            end else begin
                hit_d = hit_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            ball_x_q <= CX;
            ball_y_q <= CY;
            dir_x_q  <= 1'b1;
            dir_y_q  <= 1'b1;
            vx_q     <= V_INIT;
            hit_q    <= '0;
            delay_q  <= '0;
            score1_q <= '0;
            score2_q <= '0;
            scorer_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ball_x_q <= ball_x_d;
            ball_y_q <= ball_y_d;
            dir_x_q  <= dir_x_d;
            dir_y_q  <= dir_y_d;
            vx_q     <= vx_d;
            hit_q    <= hit_d;
            delay_q  <= delay_d;
            score1_q <= score1_d;
            score2_q <= score2_d;
            scorer_q <= scorer_d;
        end
    end

    assign ball_x    = ball_x_q;
    assign ball_y    = ball_y_q;
    assign score1    = score1_q;
    assign score2    = score2_q;
    assign point_p1  = (state_q == S_POINT) && scorer_q;
    assign point_p2  = (state_q == S_POINT) && !scorer_q;
    assign game_over = (state_q == S_OVER);
    assign state_o   = state_q;
endmodule

// File: tb/tb_pong_ball_engine.sv
// Directed bench for pong_ball_engine: serve, wall/paddle bounces, speed-up, scoring, game over, async reset.
module tb_pong_ball_engine;
    logic        clk = 1'b0;
    logic        reset;
    logic        tick;
    logic        serve;
    logic [9:0]  pad1_y, pad2_y;
    logic [10:0] ball_x;
    logic [9:0]  ball_y;
    logic [3:0]  score1, score2;
    logic        point_p1, point_p2, game_over;
    logic [2:0]  state_o;

    bit pad1_track = 1'b1;
    bit pad2_track = 1'b1;
    int n_tests = 0;
    int n_fail  = 0;

    // Tracking paddles always sit level with the ball; a parked paddle at 1000 can never overlap it.
    assign pad1_y = pad1_track ? ball_y : 10'd1000;
    assign pad2_y = pad2_track ? ball_y : 10'd1000;

    always #5 clk = ~clk;

    pong_ball_engine dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .serve     (serve),
        .pad1_y    (pad1_y),
        .pad2_y    (pad2_y),
        .ball_x    (ball_x),
        .ball_y    (ball_y),
        .score1    (score1),
        .score2    (score2),
        .point_p1  (point_p1),
        .point_p2  (point_p2),
        .game_over (game_over),
        .state_o   (state_o)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Returns at the negedge after the edge that consumed the tick.
    task automatic do_tick();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic pulse_serve();
        @(negedge clk);
        serve = 1'b1;
        @(negedge clk);
        serve = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int hits;
        int bx;
        int dx;
        int dy;
        bit got;

        reset = 1'b0;
        tick  = 1'b0;
        serve = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_x", ball_x, 315);
        check_val("rst_y", ball_y, 235);
        check_val("rst_s1", score1, 0);
        check_val("rst_s2", score2, 0);
        check_val("rst_over", game_over, 0);
        check_val("rst_state", state_o, 0);
        check_val("rst_p1", point_p1, 0);
        check_val("rst_p2", point_p2, 0);

        reset = 1'b1;
        @(negedge clk);
        do_tick();
        check_val("idle_tick_ignored", state_o, 0);

        pulse_serve();
        check_val("serve_to_delay", state_o, 1);
        repeat (59) do_tick();
        check_val("delay_59", state_o, 1);
        check_val("delay_hold_x", ball_x, 315);
        do_tick();
        check_val("delay_60_move", state_o, 2);
        check_val("move_start_x", ball_x, 315);

        do_tick();
        check_val("t1_x", ball_x, 317);
        check_val("t1_y", ball_y, 237);
        repeat (116) do_tick();
        check_val("t117_x", ball_x, 549);
        check_val("t117_y", ball_y, 469);
        do_tick();
        check_val("bottom_clamp_y", ball_y, 470);
        check_val("t118_x", ball_x, 551);
        do_tick();
        check_val("bottom_up_y", ball_y, 468);
        repeat (28) do_tick();
        check_val("t147_x", ball_x, 609);
        do_tick();
        check_val("right_pad_clamp_x", ball_x, 610);
        do_tick();
        check_val("right_pad_left_x", ball_x, 608);
        repeat (204) do_tick();
        check_val("top_clamp_y", ball_y, 0);
        check_val("t353_x", ball_x, 200);
        repeat (84) do_tick();
        check_val("t437_x", ball_x, 32);
        do_tick();
        check_val("left_pad_clamp_x", ball_x, 30);
        check_val("t438_y", ball_y, 170);

        // Two paddle hits so far; each later bounce lands exactly on a paddle face.
        hits = 2;
        for (int t = 0; t < 6000 && hits < 28; t++) begin
            do_tick();
            if (ball_x == 30 || ball_x == 610) begin
                hits++;
                if (hits == 4 || hits == 20 || hits == 24 || hits == 28) begin
                    bx = ball_x;
                    do_tick();
                    dx = (bx == 30) ? int'(ball_x) - bx : bx - int'(ball_x);
                    case (hits)
                        4:       check_val("speed_after_4", dx, 3);
                        20:      check_val("speed_after_20", dx, 7);
                        24:      check_val("speed_after_24", dx, 8);
                        default: check_val("speed_after_28", dx, 8);
                    endcase
                end
            end
        end
        check_val("hit_count_reached", hits, 28);

        pad1_track = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 400 && !got; t++) begin
            do_tick();
            if (ball_x == 0) got = 1'b1;
        end
        check_val("p2_miss_seen", got, 1);
        check_val("p2_point_state", state_o, 3);
        check_val("p2_pulse", point_p2, 1);
        check_val("p2_no_p1_pulse", point_p1, 0);
        @(negedge clk);
        check_val("p2_pulse_gone", point_p2, 0);
        check_val("p2_score", score2, 1);
        check_val("p2_to_delay", state_o, 1);
        check_val("p2_centre_x", ball_x, 315);
        check_val("p2_centre_y", ball_y, 235);

        pad1_track = 1'b1;
        pad2_track = 1'b0;
        repeat (60) do_tick();
        check_val("p2_serve_move", state_o, 2);
        do_tick();
        check_val("p2_serve_left_vx2", ball_x, 313);
        dy = (ball_y > 235) ? int'(ball_y) - 235 : 235 - int'(ball_y);
        check_val("p2_serve_vy", dy, 2);

        for (int p = 1; p <= 9; p++) begin
            got = 1'b0;
            for (int t = 0; t < 600 && !got; t++) begin
                do_tick();
                if (point_p1) got = 1'b1;
            end
            check_val("p1_point_seen", got, 1);
            check_val("p1_wall_x", ball_x, 630);
            @(negedge clk);
            check_val("p1_score", score1, p);
            check_val("p1_next_state", state_o, (p == 9) ? 4 : 1);
        end
        check_val("over_flag", game_over, 1);
        repeat (5) do_tick();
        check_val("over_tick_state", state_o, 4);
        check_val("over_tick_x", ball_x, 315);
        check_val("over_tick_y", ball_y, 235);
        check_val("over_s1_frozen", score1, 9);
        check_val("over_s2_frozen", score2, 1);

        pulse_serve();
        check_val("restart_state", state_o, 1);
        check_val("restart_s1", score1, 0);
        check_val("restart_s2", score2, 0);
        check_val("restart_over", game_over, 0);
        repeat (70) do_tick();
        check_val("restart_flight_x", ball_x, 335);

        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check_val("async_rst_x", ball_x, 315);
        check_val("async_rst_y", ball_y, 235);
        check_val("async_rst_state", state_o, 0);
        check_val("async_rst_over", game_over, 0);
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pong_ball_engine.md
Name: pong_ball_engine

Overview:
- Parametrised ball-physics and scoring engine for the pong game. It replaces the hard-coded ball motion and bounds logic in the top level.
- Advances the ball once per frame `tick` and handles inclusive wall and paddle collisions with clamping.
- Counts points and game-over, applies paddle-hit speed-up, and runs a serve delay between points.
- Outputs feed the `object` instances (ball X/Y) and the SSD/LED score display.

Parameters:
- SCREEN_W, 640, playfield width in pixels
- SCREEN_H, 480, playfield height in pixels
- BALL_SIZE, 10, ball edge length (square)
- PAD_W, 10, paddle width
- PAD_H, 50, paddle height
- PAD_L_X, 20, left paddle left edge X (player 1)
- PAD_R_X, 620, right paddle left edge X (player 2)
- SPEED_INIT, 2, initial X and Y speed (pixels/tick)
- SPEED_MAX, 8, X speed saturation value
- HITS_PER_UP, 4, paddle hits per +1 X speed
- WIN_SCORE, 9, score that ends the game
- SERVE_DELAY, 60, ticks held at centre before each serve

Ports:
- clk  in  1  system clock, same domain as game logic
- reset  in  1  asynchronous, active-low; 0 = reset
- tick  in  1  one-clk frame strobe (e.g. DIV_CLK[18] edge-detected)
- serve  in  1  level; start game / restart after game over
- pad1_y  in  10  player 1 paddle top Y
- pad2_y  in  10  player 2 paddle top Y
- ball_x  out  11  ball left edge X
- ball_y  out  10  ball top edge Y
- score1  out  4  player 1 score
- score2  out  4  player 2 score
- point_p1  out  1  one-clk pulse: player 1 scored
- point_p2  out  1  one-clk pulse: player 2 scored
- game_over  out  1  high while in S_OVER
- state_o  out  3  current FSM state encoding, for debug SSD

Behaviour:
- Reset (reset=0, async):
  - state=S_IDLE; ball_x=(SCREEN_W-BALL_SIZE)/2, ball_y=(SCREEN_H-BALL_SIZE)/2 (315,235).
  - Scores 0, pulses 0, game_over 0.
  - dir_x=right, dir_y=down, vx=vy=SPEED_INIT, hit count 0, delay count 0.
  - Reset mid-operation aborts immediately to these values.
- States: S_IDLE=0, S_DELAY=1, S_MOVE=2, S_POINT=3, S_OVER=4. Other codes go to S_IDLE.
- S_IDLE: ball centred; serve=1 → S_DELAY, delay count cleared.
- S_DELAY: ball held at centre; count increments on each tick; at count==SERVE_DELAY-1 with tick → S_MOVE.
- S_MOVE, on tick only, ball registers update on the same clk edge (latency 1 clk from tick).
- Y axis:
  - Down: if ball_y+vy >= SCREEN_H-BALL_SIZE → ball_y=SCREEN_H-BALL_SIZE and dir_y flips; else ball_y+=vy.
  - Up: if ball_y <= vy → ball_y=0 and dir_y flips; else ball_y-=vy.
  - Comparisons are inclusive, never equality-only.
- X axis, moving left, evaluated in this order:
  - Paddle: if ball_x >= PAD_L_X+PAD_W and ball_x-vx <= PAD_L_X+PAD_W and (ball_y+BALL_SIZE > pad1_y) and (ball_y < pad1_y+PAD_H) → ball_x=PAD_L_X+PAD_W, dir_x=right, hit count++.
  - Miss: else if ball_x <= vx → ball_x=0, → S_POINT with scorer=player 2.
  - Otherwise: ball_x-=vx.
- X axis, moving right, mirrored:
  - Face: edge ball_x+BALL_SIZE against PAD_R_X, using pad2_y; clamp ball_x=PAD_R_X-BALL_SIZE.
  - Wall: ball_x+vx >= SCREEN_W-BALL_SIZE → ball_x=SCREEN_W-BALL_SIZE, scorer=player 1.
- Paddle overlap uses the pre-move ball_y.
- Simultaneous Y-wall and paddle hit in one tick are both applied.
- Speed-up: when hit count reaches HITS_PER_UP, it clears and vx=min(vx+1,SPEED_MAX). vy is fixed at SPEED_INIT.
- S_POINT (exactly 1 clk):
  - Scorer's score += 1 (4-bit, saturates at 15); the matching point_pX pulse is high this clk.
  - vx=SPEED_INIT, hit count 0, ball re-centred.
  - dir_x points toward the player who conceded; dir_y toggles.
  - New score == WIN_SCORE → S_OVER, else → S_DELAY.
- S_OVER: ball centred, game_over=1, scores frozen, ticks ignored. serve=1 → scores cleared, dir_x=right, → S_DELAY.
- serve is ignored outside S_IDLE and S_OVER.
- tick outside S_DELAY and S_MOVE has no effect.
- All arithmetic is unsigned and sized to ball_x/ball_y width; no intermediate wrap is permitted. Use (W+1)-bit compares where a sum can exceed the range.

Test Plan:
- Reset release, serve=1, 60 ticks → S_MOVE; next tick: ball_x 315→317, ball_y 235→237.
- Ball at y=468 moving down, vy=2 → ball_y=470, dir_y up; next tick 468.
- Ball moving left at x=31, vx=2, ball_y=100, pad1_y=80 → ball_x=30, dir_x right, hit count 1. Repeat with pad1_y=200 → ball continues to x=0, point_p2 pulses 1 clk, score2=1, ball at (315,235), dir_x left.
- 4 consecutive paddle hits with SPEED_INIT=2 → vx=3; 24 further hits → vx saturates at 8; next point → vx=2.
- score1=8, player 1 scores → score1=9, game_over=1, ticks ignored; serve=1 → scores 0, S_DELAY.
- Assert reset=0 mid-flight at (400,300) → outputs return to reset values asynchronously, before the next clk edge.
